// File: rtl/pkt_loader.sv
// Packet loader: captures one inbound packet into a local buffer, replays it to the
// sorter as a burst of writes, then waits for the sorter to signal completion.
module pkt_loader #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              val_i,
  output logic              ready_o,
  output logic              wren_o,
  output logic [AWIDTH-1:0] cntr_o,
  output logic [DWIDTH-1:0] data_o,
  input  logic              sort_eop_i,
  output logic              ovf_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  localparam logic [AWIDTH:0]   FULL      = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0]   COUNT_ONE = (AWIDTH + 1)'(1);
  localparam logic [AWIDTH-1:0] CNTR_ONE  = AWIDTH'(1);

  logic [1:0]        state_q, state_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [AWIDTH-1:0] cntr_q, cntr_d;
  logic              ovf_q, ovf_d;

  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] buffer [2**AWIDTH];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    cntr_d   = cntr_q;
    ovf_d    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    case (state_q)
      IDLE, RECV: begin
        if (val_i && sop_i) begin
          // A new sop always restarts capture, discarding any partial packet.
          wr_en    = 1'b1;
          count_d  = COUNT_ONE;
          rd_ptr_d = '0;
          if (eop_i) begin
            cntr_d  = CNTR_ONE;
            state_d = LOAD;
          end else begin
            state_d = RECV;
          end
        end else if (val_i && (state_q == RECV)) begin
          if (count_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_addr = count_q[AWIDTH-1:0];
            count_d = count_q + 1'b1;
          end
          if (eop_i) begin
            cntr_d   = count_d[AWIDTH-1:0];
            rd_ptr_d = '0;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (rd_ptr_q == count_q - 1'b1) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (sort_eop_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      cntr_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      cntr_q   <= cntr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: only the first count entries are ever read back.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      buffer[wr_addr] <= data_i;
    end
  end

  assign ready_o = (state_q == IDLE) || (state_q == RECV);
  assign wren_o  = (state_q == LOAD);
  assign data_o  = wren_o ? buffer[rd_ptr_q[AWIDTH-1:0]] : '0;
  assign cntr_o  = cntr_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_pkt_loader.sv
// Directed self-checking bench for pkt_loader: captures the write burst seen by the
// sorter and compares it against hand-written expected packets.
module tb_pkt_loader;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] data_i;
  logic          sop_i;
  logic          eop_i;
  logic          val_i;
  logic          ready_o;
  logic          wren_o;
  logic [AW-1:0] cntr_o;
  logic [DW-1:0] data_o;
  logic          sort_eop_i;
  logic          ovf_o;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];

  pkt_loader #(
    .DWIDTH(DW),
    .AWIDTH(AW)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .sop_i     (sop_i),
    .eop_i     (eop_i),
    .val_i     (val_i),
    .ready_o   (ready_o),
    .wren_o    (wren_o),
    .cntr_o    (cntr_o),
    .data_o    (data_o),
    .sort_eop_i(sort_eop_i),
    .ovf_o     (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every sorter write and overflow pulse, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (wren_o) got_q.push_back(data_o);
    if (ovf_o) ovf_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic sop, input logic eop);
    data_i = d;
    sop_i  = sop;
    eop_i  = eop;
    val_i  = 1'b1;
    @(posedge clk_i);
    #1;
    val_i  = 1'b0;
    sop_i  = 1'b0;
    eop_i  = 1'b0;
    data_i = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic finish_load();
    int n = 0;
    while (wren_o && n < 40) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check_eq("load_end", 32'(wren_o), 32'd0);
  endtask

  task automatic release_sorter();
    sort_eop_i = 1'b1;
    @(posedge clk_i);
    #1;
    sort_eop_i = 1'b0;
    check_eq("ready_after_sort_eop", 32'(ready_o), 32'd1);
  endtask

  task automatic check_pkt(input string tag, input logic [AW-1:0] cntr, input int ovf_exp);
    check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_d%0d", tag, i),
               (got_q.size() > i) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
    end
    check_eq({tag, "_cntr"}, 32'(cntr_o), 32'(cntr));
    check_eq({tag, "_ovf"}, 32'(ovf_cnt), 32'(ovf_exp));
    idle(2);
    check_eq({tag, "_wait_ready"}, 32'(ready_o), 32'd0);
    check_eq({tag, "_wait_cntr"}, 32'(cntr_o), 32'(cntr));
  endtask

  task automatic clear();
    got_q.delete();
    exp_q.delete();
    ovf_cnt = 0;
  endtask

  initial begin
    rst_i = 1'b1; data_i = '0; sop_i = 1'b0; eop_i = 1'b0; val_i = 1'b0; sort_eop_i = 1'b0;
    #3;
    check_eq("rst_ready", 32'(ready_o), 32'd1);
    check_eq("rst_wren", 32'(wren_o), 32'd0);
    check_eq("rst_cntr", 32'(cntr_o), 32'd0);
    check_eq("rst_data", 32'(data_o), 32'd0);
    check_eq("rst_ovf", 32'(ovf_o), 32'd0);
    #14;
    rst_i = 1'b0;
    idle(1);

    // 5-word packet with one-cycle write latency.
    clear();
    send(8'd9, 1'b1, 1'b0);
    send(8'd3, 1'b0, 1'b0);
    send(8'd7, 1'b0, 1'b0);
    send(8'd1, 1'b0, 1'b0);
    check_eq("p5_no_early_wren", 32'(wren_o), 32'd0);
    send(8'd5, 1'b0, 1'b1);
    check_eq("p5_first_wren", 32'(wren_o), 32'd1);
    check_eq("p5_first_data", 32'(data_o), 32'd9);
    check_eq("p5_ready_low", 32'(ready_o), 32'd0);
    finish_load();
    exp_q = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5};
    check_pkt("p5", 4'd5, 0);
    release_sorter();

    // Single-word packet.
    clear();
    send(8'hAA, 1'b1, 1'b1);
    check_eq("p1_wren", 32'(wren_o), 32'd1);
    check_eq("p1_data", 32'(data_o), 32'hAA);
    finish_load();
    exp_q = '{8'hAA};
    check_pkt("p1", 4'd1, 0);
    release_sorter();

    // 18-word packet overflows a 16-entry buffer.
    clear();
    for (int i = 0; i < 18; i++) begin
      send(8'(i + 1), (i == 0), (i == 17));
    end
    finish_load();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i + 1));
    check_pkt("p18", 4'd0, 2);
    release_sorter();

    // Restart on sop mid-packet.
    clear();
    send(8'd11, 1'b1, 1'b0);
    send(8'd12, 1'b0, 1'b0);
    send(8'd21, 1'b1, 1'b0);
    send(8'd22, 1'b0, 1'b0);
    send(8'd23, 1'b0, 1'b0);
    send(8'd24, 1'b0, 1'b1);
    finish_load();
    exp_q = '{8'd21, 8'd22, 8'd23, 8'd24};
    check_pkt("prs", 4'd4, 0);
    release_sorter();

    // Asynchronous reset during the third LOAD cycle.
    clear();
    send(8'd9, 1'b1, 1'b0);
    send(8'd3, 1'b0, 1'b0);
    send(8'd7, 1'b0, 1'b0);
    send(8'd1, 1'b0, 1'b0);
    send(8'd5, 1'b0, 1'b1);
    idle(2);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("lrst_wren", 32'(wren_o), 32'd0);
    check_eq("lrst_ready", 32'(ready_o), 32'd1);
    check_eq("lrst_cntr", 32'(cntr_o), 32'd0);
    check_eq("lrst_data", 32'(data_o), 32'd0);
    check_eq("lrst_partial_len", 32'(got_q.size()), 32'd2);
    got_q.delete();
    rst_i = 1'b0;
    idle(4);
    check_eq("lrst_no_wren_after", 32'(got_q.size()), 32'd0);

    // A sop word is accepted on the very first edge after reset release.
    clear();
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    send(8'h5C, 1'b1, 1'b1);
    check_eq("post_rst_wren", 32'(wren_o), 32'd1);
    check_eq("post_rst_data", 32'(data_o), 32'h5C);
    check_eq("post_rst_cntr", 32'(cntr_o), 32'd1);
    finish_load();
    release_sorter();

    // Stray words and sort_eop while idle change nothing.
    clear();
    send(8'h31, 1'b0, 1'b0);
    send(8'h32, 1'b0, 1'b1);
    sort_eop_i = 1'b1;
    idle(1);
    sort_eop_i = 1'b0;
    idle(2);
    check_eq("idle_no_wren", 32'(got_q.size()), 32'd0);
    check_eq("idle_ready", 32'(ready_o), 32'd1);
    check_eq("idle_cntr", 32'(cntr_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
